// File: rtl/axilite_s.sv
// AXI4-Lite slave that exposes NUM_REGS 32-bit registers with byte-lane writes.
// The write and read channels are independent two-state FSMs.
module axilite_s #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    logic [31:0] regs_q [NUM_REGS];

    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_latched_q, aw_latched_d;
    logic        w_latched_q, w_latched_d;
    logic [29:0] awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_hs, w_hs, wr_commit, wr_in_range;
    logic [29:0] wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    rd_state_e   rd_state_q, rd_state_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [29:0] rd_idx;
    logic [31:0] rd_word;
    logic        rd_in_range;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies depend only on registered state, never on the master's valids.
    assign s_axi_awready = (wr_state_q == WrIdle) && !aw_latched_q;
    assign s_axi_wready  = (wr_state_q == WrIdle) && !w_latched_q;
    assign s_axi_arready = (rd_state_q == RdIdle);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    // A beat handshaking this cycle is used directly, otherwise the latched copy.
    assign wr_idx      = aw_latched_q ? awidx_q : s_axi_awaddr[31:2];
    assign wr_data     = w_latched_q ? wdata_q : s_axi_wdata;
    assign wr_strb     = w_latched_q ? wstrb_q : s_axi_wstrb;
    assign wr_in_range = {2'b00, wr_idx} < NUM_REGS;

    always_comb begin
        wr_state_d   = wr_state_q;
        aw_latched_d = aw_latched_q;
        w_latched_d  = w_latched_q;
        awidx_d      = awidx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        wr_commit    = 1'b0;
        case (wr_state_q)
            WrIdle: begin
                if (aw_hs) begin
                    aw_latched_d = 1'b1;
                    awidx_d      = s_axi_awaddr[31:2];
                end
                if (w_hs) begin
                    w_latched_d = 1'b1;
                    wdata_d     = s_axi_wdata;
                    wstrb_d     = s_axi_wstrb;
                end
                if ((aw_latched_q || aw_hs) && (w_latched_q || w_hs)) begin
                    wr_commit  = 1'b1;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_in_range ? RespOkay : RespSlverr;
                    wr_state_d = WrResp;
                end
            end
            WrResp: begin
                if (s_axi_bready) begin
                    bvalid_d     = 1'b0;
                    aw_latched_d = 1'b0;
                    w_latched_d  = 1'b0;
                    wr_state_d   = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_state_q   <= WrIdle;
            aw_latched_q <= 1'b0;
            w_latched_q  <= 1'b0;
            awidx_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RespOkay;
        end else begin
            wr_state_q   <= wr_state_d;
            aw_latched_q <= aw_latched_d;
            w_latched_q  <= w_latched_d;
            awidx_q      <= awidx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
        end
    end

    // An out-of-range index matches no register, so it writes nothing.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int r = 0; r < int'(NUM_REGS); r++) regs_q[r] <= '0;
        end else if (wr_commit) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (wr_idx == 30'(r)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) regs_q[r][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_idx      = s_axi_araddr[31:2];
    assign rd_in_range = {2'b00, rd_idx} < NUM_REGS;

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (rd_idx == 30'(r)) rd_word = regs_q[r];
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RdIdle: begin
                if (s_axi_arvalid) begin
                    rdata_d    = rd_word;
                    rresp_d    = rd_in_range ? RespOkay : RespSlverr;
                    rvalid_d   = 1'b1;
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= RdIdle;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axilite_s.sv
// Scoreboard bench for axilite_s: stimulus pushes expected responses, a monitor
// pops and compares them whenever a B or R handshake is about to occur.
module tb_axilite_s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    axilite_s #(.NUM_REGS(16)) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_awaddr (awaddr),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_bresp  (bresp),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Monitor: inputs change at posedge+1, so a negedge sample sees the upcoming handshake.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
            else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
            else begin
                logic [33:0] e;
                e = exp_r.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rresp", 32'(rresp), 32'(e[33:32]));
            end
        end
    end

    task automatic wait_b(output int cycles);
        cycles = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin
                cycles = i;
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now("b_wait");
    endtask

    task automatic wait_r(output int cycles);
        cycles = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin
                cycles = i;
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now("r_wait");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
        int c;
        exp_b.push_back(resp);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        @(negedge clk);
        chk("aw_w_ready", 32'(awready && wready), 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_b(c);
        chk("b_latency", 32'(c), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        int c;
        exp_r.push_back({resp, d});
        arvalid = 1'b1; araddr = a;
        @(negedge clk);
        chk("ar_ready", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_r(c);
        chk("r_latency", 32'(c), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outs", {bvalid, rvalid, bresp, rresp, 26'd0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        awvalid = 0; wvalid = 0; arvalid = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        bready = 1; rready = 1;
        @(posedge clk);
        #1;
        apply_reset(3);

        // Same-cycle AW+W, then read back.
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(32'h08, 32'hDEADBEEF, 2'b00);

        // W two cycles ahead of AW, partial strobes.
        do_write(32'h0C, 32'hAABBCCDD, 4'hF, 2'b00);
        exp_b.push_back(2'b00);
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        chk("w_latched_ready", {30'd0, awready, wready}, 32'd2);
        @(posedge clk);
        #1;
        awvalid = 1'b1; awaddr = 32'h0C;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wait_b(c);
        chk("b_latency_w_first", 32'(c), 32'd0);
        do_read(32'h0C, 32'hAA22CC44, 2'b00);

        // Zero strobes: OKAY, no change.
        do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 2'b00);
        do_read(32'h0C, 32'hAA22CC44, 2'b00);

        // Out of range and top index; low address bits ignored.
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 2'b10);
        do_read(32'h40, 32'h0, 2'b10);
        do_read(32'h0B, 32'hDEADBEEF, 2'b00);
        do_write(32'h3E, 32'h12345678, 4'hF, 2'b00);
        do_read(32'h3C, 32'h12345678, 2'b00);

        // Back-pressure, plus a read sampling the register on its write-commit edge.
        bready = 1'b0; rready = 1'b0;
        exp_b.push_back(2'b00);
        exp_r.push_back({2'b00, 32'hDEADBEEF});
        awvalid = 1'b1; awaddr = 32'h08; wvalid = 1'b1; wdata = 32'h01020304; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h08;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_b", {bvalid, 1'b0, bresp, 28'd0}, 32'h8000_0000);
            chk("hold_r", {rvalid, 1'b0, rresp, 28'd0}, 32'h8000_0000);
            chk("hold_rdata", rdata, 32'hDEADBEEF);
            chk("hold_readies", {29'd0, awready, wready, arready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        #1;
        do_read(32'h08, 32'h01020304, 2'b00);

        // AW accepted, then reset before W: the write is abandoned.
        awvalid = 1'b1; awaddr = 32'h14;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_b_after_rst", 32'(bvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        do_read(32'h08, 32'h0, 2'b00);
        do_read(32'h3C, 32'h0, 2'b00);
        do_write(32'h14, 32'h00000077, 4'hF, 2'b00);
        do_read(32'h14, 32'h00000077, 2'b00);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
